// File: rtl/ysyx_210544_csr_pkg.sv
// ysyx_210544 CSR/trap shared definitions.
// CSR addresses, snapshot indices, op codes, mstatus fields, FSM states.
package ysyx_210544_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam int IDX_NONE     = 0;
  localparam int IDX_MCYCLE   = 1;
  localparam int IDX_MSTATUS  = 2;
  localparam int IDX_MIE      = 3;
  localparam int IDX_MTVEC    = 4;
  localparam int IDX_MSCRATCH = 5;
  localparam int IDX_MEPC     = 6;
  localparam int IDX_MCAUSE   = 7;

  localparam logic [1:0] CSR_OP_NONE = 2'b00;
  localparam logic [1:0] CSR_OP_RW   = 2'b01;
  localparam logic [1:0] CSR_OP_RS   = 2'b10;
  localparam logic [1:0] CSR_OP_RC   = 2'b11;

  localparam int MS_MIE  = 3;
  localparam int MS_MPIE = 7;
  localparam int MS_MPP  = 11;
  localparam int MS_FS   = 13;
  localparam int MS_XS   = 15;

  localparam int MIE_MTIE = 7;
  localparam int MIP_MTIP = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_RETURN = 2'd2
  } trap_state_e;

endpackage

// File: rtl/ysyx_210544_csr_trap_unit_counter.sv
// ysyx_210544 CSR counter: free-running, write overrides increment.
// Ports: clk, rst, inc_i, wen_i, wdata_i, cnt_o.
module ysyx_210544_csr_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         wen_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wen_i) cnt_d = wdata_i;
    else if (inc_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_210544_csr_trap_unit.sv
// ysyx_210544 M-mode CSR file with trap entry / mret sequencer.
// Ports: CSR access (ren/wen/addr/op/wdata/rdata/illegal), counters, trap/mret, redirect, difftest.
module ysyx_210544_csr_trap_unit
  import ysyx_210544_csr_pkg::*;
#(
  parameter int               XLEN         = 64,
  parameter logic [XLEN-1:0]  MSTATUS_RST  = XLEN'(64'h1800),
  parameter logic [XLEN-1:0]  MTVEC_RST    = '0,
  parameter bit               HAS_MINSTRET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_csr_ren,
  input  logic                  i_csr_wen,
  input  logic [11:0]           i_csr_addr,
  input  logic [1:0]            i_csr_op,
  input  logic [XLEN-1:0]       i_csr_wdata,
  output logic [XLEN-1:0]       o_csr_rdata,
  output logic                  o_csr_illegal,
  input  logic                  i_instret,
  input  logic                  i_timer_irq,
  input  logic                  i_trap_valid,
  input  logic [XLEN-1:0]       i_trap_cause,
  input  logic [XLEN-1:0]       i_trap_pc,
  input  logic                  i_mret,
  output logic                  o_busy,
  output logic                  o_redirect_valid,
  output logic [XLEN-1:0]       o_redirect_pc,
  output logic                  o_irq_pending,
  output logic [7:0][XLEN-1:0]  o_csrs
);

  trap_state_e     state_q;
  logic            redir_v_q;
  logic [XLEN-1:0] redir_pc_q;

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic            mtip_q;
  logic [XLEN-1:0] mcycle, minstret;

  logic            hit, idle, trap_go, mret_go, wr_go;
  logic [XLEN-1:0] cur, wval, tbase, target;
  logic            we_mcycle, we_minstret;

  function automatic logic [XLEN-1:0] csr_alu(
    input logic [1:0]      op,
    input logic [XLEN-1:0] old,
    input logic [XLEN-1:0] w
  );
    case (op)
      CSR_OP_RW: csr_alu = w;
      CSR_OP_RS: csr_alu = old | w;
      CSR_OP_RC: csr_alu = old & ~w;
      default:   csr_alu = old;
    endcase
  endfunction

  // SD summarises dirty FS/XS state of the value being written
  function automatic logic [XLEN-1:0] sd_fix(input logic [XLEN-1:0] v);
    sd_fix = v;
    sd_fix[XLEN-1] = (&v[MS_FS+:2]) | (&v[MS_XS+:2]);
  endfunction

  always_comb begin
    hit = 1'b1;
    cur = '0;
    case (i_csr_addr)
      CSR_MSTATUS:  cur = mstatus_q;
      CSR_MIE:      cur = mie_q;
      CSR_MTVEC:    cur = mtvec_q;
      CSR_MSCRATCH: cur = mscratch_q;
      CSR_MEPC:     cur = mepc_q;
      CSR_MCAUSE:   cur = mcause_q;
      CSR_MIP:      cur[MIP_MTIP] = mtip_q;
      CSR_MCYCLE:   cur = mcycle;
      CSR_MINSTRET: cur = minstret;
      default:      hit = 1'b0;
    endcase
  end

  assign o_csr_rdata   = (i_csr_ren && hit) ? cur : '0;
  assign o_csr_illegal = !hit && (i_csr_ren || i_csr_wen);

  assign idle    = (state_q == ST_IDLE);
  assign trap_go = idle && i_trap_valid;
  assign mret_go = idle && i_mret && !i_trap_valid;
  assign wr_go   = i_csr_wen && (i_csr_op != CSR_OP_NONE) && hit
                   && !trap_go && !mret_go;
  assign wval    = csr_alu(i_csr_op, cur, i_csr_wdata);

  assign we_mcycle   = wr_go && (i_csr_addr == CSR_MCYCLE);
  assign we_minstret = wr_go && (i_csr_addr == CSR_MINSTRET);

  // vectored mode only applies to interrupts
  assign tbase  = {mtvec_q[XLEN-1:2], 2'b00};
  assign target = (mtvec_q[1:0] == 2'b01 && i_trap_cause[XLEN-1])
                  ? tbase + {i_trap_cause[XLEN-3:0], 2'b00}
                  : tbase;

  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (trap_go) begin
      mepc_d                = {i_trap_pc[XLEN-1:2], 2'b00};
      mcause_d              = i_trap_cause;
      mstatus_d[MS_MPIE]    = mstatus_q[MS_MIE];
      mstatus_d[MS_MIE]     = 1'b0;
      mstatus_d[MS_MPP+:2]  = 2'b11;
    end else if (mret_go) begin
      mstatus_d[MS_MIE]     = mstatus_q[MS_MPIE];
      mstatus_d[MS_MPIE]    = 1'b1;
      mstatus_d[MS_MPP+:2]  = 2'b11;
    end else if (wr_go) begin
      case (i_csr_addr)
        CSR_MSTATUS:  mstatus_d  = sd_fix(wval);
        CSR_MIE:      mie_d      = wval;
        CSR_MTVEC:    mtvec_d    = wval;
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = {wval[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wval;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= MSTATUS_RST;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtip_q     <= 1'b0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtip_q     <= i_timer_irq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      redir_v_q  <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trap_go) begin
            state_q    <= ST_ENTER;
            redir_v_q  <= 1'b1;
            redir_pc_q <= target;
          end else if (mret_go) begin
            state_q    <= ST_RETURN;
            redir_v_q  <= 1'b1;
            redir_pc_q <= mepc_q;
          end else begin
            redir_v_q  <= 1'b0;
          end
        end
        ST_ENTER, ST_RETURN: begin
          state_q   <= ST_IDLE;
          redir_v_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          redir_v_q <= 1'b0;
        end
      endcase
    end
  end

  ysyx_210544_csr_counter #(.W(XLEN)) u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (1'b1),
    .wen_i   (we_mcycle),
    .wdata_i (wval),
    .cnt_o   (mcycle)
  );

  generate
    if (HAS_MINSTRET) begin : g_minstret
      ysyx_210544_csr_counter #(.W(XLEN)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (i_instret),
        .wen_i   (we_minstret),
        .wdata_i (wval),
        .cnt_o   (minstret)
      );
    end else begin : g_no_minstret
      assign minstret = '0;
    end
  endgenerate

  assign o_busy        = !idle;
  // a reset landing on the redirect cycle suppresses the pulse
  assign o_redirect_valid = redir_v_q && !rst;
  assign o_redirect_pc    = redir_pc_q;
  assign o_irq_pending    = mstatus_q[MS_MIE] && mie_q[MIE_MTIE] && mtip_q;

  assign o_csrs[IDX_NONE]     = '0;
  assign o_csrs[IDX_MCYCLE]   = mcycle;
  assign o_csrs[IDX_MSTATUS]  = mstatus_q;
  assign o_csrs[IDX_MIE]      = mie_q;
  assign o_csrs[IDX_MTVEC]    = mtvec_q;
  assign o_csrs[IDX_MSCRATCH] = mscratch_q;
  assign o_csrs[IDX_MEPC]     = mepc_q;
  assign o_csrs[IDX_MCAUSE]   = mcause_q;

endmodule

// File: tb/tb_ysyx_210544_csr_trap_unit.sv
// Self-checking bench for ysyx_210544_csr_trap_unit.
// Directed steps; expectations queued at stimulus, popped at observation.
module tb_ysyx_210544_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ren = 1'b0, wen = 1'b0;
  logic [11:0] addr = '0;
  logic [1:0]  op = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        illegal;
  logic        instret = 1'b0, timer = 1'b0;
  logic        trap_v = 1'b0, mret = 1'b0;
  logic [63:0] cause = '0, tpc = '0;
  logic        busy, rv, irqp;
  logic [63:0] rpc;
  logic [7:0][63:0] csrs;

  ysyx_210544_csr_trap_unit dut (
    .clk              (clk),
    .rst              (rst),
    .i_csr_ren        (ren),
    .i_csr_wen        (wen),
    .i_csr_addr       (addr),
    .i_csr_op         (op),
    .i_csr_wdata      (wdata),
    .o_csr_rdata      (rdata),
    .o_csr_illegal    (illegal),
    .i_instret        (instret),
    .i_timer_irq      (timer),
    .i_trap_valid     (trap_v),
    .i_trap_cause     (cause),
    .i_trap_pc        (tpc),
    .i_mret           (mret),
    .o_busy           (busy),
    .o_redirect_valid (rv),
    .o_redirect_pc    (rpc),
    .o_irq_pending    (irqp),
    .o_csrs           (csrs)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty got %0h exp none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s got %0h exp %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cwr(input logic [11:0] a, input logic [1:0] o,
                     input logic [63:0] d);
    @(negedge clk);
    wen = 1'b1; addr = a; op = o; wdata = d;
    tick();
    wen = 1'b0; op = 2'b00;
  endtask

  task automatic crd(input string tag, input logic [11:0] a,
                     input logic [63:0] v);
    @(negedge clk);
    push(tag, v);
    ren = 1'b1; addr = a;
    #1;
    pop_chk(rdata);
    ren = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    push("rst_busy", 64'd0);
    push("rst_rv", 64'd0);
    push("rst_rpc", 64'd0);
    pop_chk({63'd0, busy});
    pop_chk({63'd0, rv});
    pop_chk(rpc);
    rst = 1'b0;
    crd("rd_mstatus", 12'h300, 64'h1800);
    crd("rd_mepc", 12'h341, 64'h0);

    // RW/RS/RC
    cwr(12'h340, 2'b01, 64'hF0);
    crd("scr_rw", 12'h340, 64'hF0);
    cwr(12'h340, 2'b10, 64'h0F);
    crd("scr_rs", 12'h340, 64'hFF);
    cwr(12'h340, 2'b11, 64'hF0);
    crd("scr_rc", 12'h340, 64'h0F);
    push("snap_scr", 64'h0F);
    pop_chk(csrs[5]);

    // SD, illegal, mepc mask, mip
    cwr(12'h300, 2'b01, 64'h6000);
    crd("mstatus_sd", 12'h300, 64'h8000_0000_0000_6000);
    @(negedge clk);
    push("ill_rdata", 64'h0);
    push("ill_flag", 64'h1);
    ren = 1'b1; addr = 12'h7C0;
    #1;
    pop_chk(rdata);
    pop_chk({63'd0, illegal});
    ren = 1'b0;
    cwr(12'h341, 2'b01, 64'h1237);
    crd("mepc_mask", 12'h341, 64'h1234);
    cwr(12'h344, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    crd("mip_ro", 12'h344, 64'h0);
    @(negedge clk);
    timer = 1'b1;
    tick();
    crd("mip_mtip", 12'h344, 64'h80);

    // trap entry, vectored interrupt
    cwr(12'h305, 2'b01, 64'h8000_0001);
    cwr(12'h300, 2'b01, 64'h1808);
    cwr(12'h304, 2'b01, 64'h80);
    push("irq_pend", 64'h1);
    pop_chk({63'd0, irqp});
    @(negedge clk);
    trap_v = 1'b1;
    cause = 64'h8000_0000_0000_0007;
    tpc = 64'h8000_1236;
    push("ent_busy", 64'h1);
    push("ent_rv", 64'h1);
    push("ent_pc", 64'h8000_001C);
    push("ent_mepc", 64'h8000_1234);
    push("ent_mcause", 64'h8000_0000_0000_0007);
    push("ent_mstatus", 64'h1880);
    push("ent_irqp", 64'h0);
    tick();
    trap_v = 1'b0;
    pop_chk({63'd0, busy});
    pop_chk({63'd0, rv});
    pop_chk(rpc);
    pop_chk(csrs[6]);
    pop_chk(csrs[7]);
    pop_chk(csrs[2]);
    pop_chk({63'd0, irqp});
    push("ent_done_busy", 64'h0);
    push("ent_done_rv", 64'h0);
    tick();
    pop_chk({63'd0, busy});
    pop_chk({63'd0, rv});

    // mret
    @(negedge clk);
    mret = 1'b1;
    push("ret_rv", 64'h1);
    push("ret_pc", 64'h8000_1234);
    push("ret_mstatus", 64'h1888);
    tick();
    mret = 1'b0;
    pop_chk({63'd0, rv});
    pop_chk(rpc);
    pop_chk(csrs[2]);
    push("ret_done_busy", 64'h0);
    tick();
    pop_chk({63'd0, busy});

    // trap + mret + mcycle write in one cycle, then reset during ENTER
    push("mcyc_wr", 64'd1000);
    cwr(12'hB00, 2'b01, 64'd1000);
    pop_chk(csrs[1]);
    @(negedge clk);
    trap_v = 1'b1; mret = 1'b1;
    cause = 64'd2; tpc = 64'h8000_2000;
    wen = 1'b1; addr = 12'hB00; op = 2'b01; wdata = 64'd5;
    push("sim_mcycle", 64'd1001);
    push("sim_rv", 64'h1);
    push("sim_pc", 64'h8000_0000);
    push("sim_mcause", 64'd2);
    push("sim_mstatus", 64'h1880);
    tick();
    trap_v = 1'b0; mret = 1'b0; wen = 1'b0; op = 2'b00;
    pop_chk(csrs[1]);
    pop_chk({63'd0, rv});
    pop_chk(rpc);
    pop_chk(csrs[7]);
    pop_chk(csrs[2]);
    rst = 1'b1;
    push("rst_mid_rv", 64'h0);
    #1;
    pop_chk({63'd0, rv});
    push("rst2_busy", 64'h0);
    push("rst2_rv", 64'h0);
    push("rst2_mstatus", 64'h1800);
    tick();
    rst = 1'b0;
    pop_chk({63'd0, busy});
    pop_chk({63'd0, rv});
    pop_chk(csrs[2]);

    // minstret counting and mcycle wrap
    @(negedge clk);
    instret = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    instret = 1'b0;
    crd("minstret", 12'hB02, 64'd3);
    push("wrap_max", 64'hFFFF_FFFF_FFFF_FFFF);
    cwr(12'hB00, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    pop_chk(csrs[1]);
    push("wrap_zero", 64'h0);
    tick();
    pop_chk(csrs[1]);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL sb_left got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
